// File: rtl/vme_rd_burst_mux.sv
// Registered read-back multiplexer for the VME64x slave register file.
// Bursts over consecutive channel indices with wrap, valid/ready output, abort and out-of-range flagging.
module vme_rd_burst_mux #(
    parameter int              DW          = 8,
    parameter int              NCH         = 8,
    parameter int              SW          = 3,
    parameter int              SEL_REVERSE = 1,
    parameter logic [DW-1:0]   FILL        = {DW{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*DW-1:0] din,
    input  logic              rd_req,
    input  logic [SW-1:0]     start_sel,
    input  logic [SW:0]       burst_len,
    input  logic              abort,
    output logic              busy,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              dout_err
);

    localparam int NSLOT = 2 ** SW;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   index, index_nxt;
    logic [SW:0]     remaining, remaining_nxt;
    logic [DW-1:0]   dout_nxt;
    logic            valid_nxt, last_nxt, err_nxt;

    logic [DW-1:0]   slot_data [NSLOT];
    logic [NSLOT-1:0] slot_oor;
    logic [SW-1:0]   load_index, phys;
    logic [DW-1:0]   beat_data;
    logic            beat_err;
    logic            accept, load;

    // Every index slot gets a value; slots with no physical channel read FILL and flag an error.
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < NCH) begin : g_real
            assign slot_data[k] = din[k*DW +: DW];
            assign slot_oor[k]  = 1'b0;
        end else begin : g_fill
            assign slot_data[k] = FILL;
            assign slot_oor[k]  = 1'b1;
        end
    end

    // The first beat uses start_sel directly because index is only loaded on the acceptance edge.
    assign load_index = (state == IDLE) ? start_sel : index;
    assign phys       = (SEL_REVERSE != 0) ? ~load_index : load_index;
    assign beat_data  = slot_data[phys];
    assign beat_err   = slot_oor[phys];

    assign accept = dout_valid & dout_ready;
    assign busy   = (state == BURST);

    always_comb begin
        state_nxt     = state;
        index_nxt     = index;
        remaining_nxt = remaining;
        dout_nxt      = dout;
        valid_nxt     = dout_valid;
        last_nxt      = dout_last;
        err_nxt       = dout_err;
        load          = 1'b0;

        case (state)
            IDLE: begin
                if (rd_req) begin
                    load          = 1'b1;
                    state_nxt     = BURST;
                    index_nxt     = start_sel + 1'b1;
                    remaining_nxt = (burst_len == '0) ? '0 : burst_len - 1'b1;
                end
            end
            BURST: begin
                if (abort) begin
                    state_nxt     = IDLE;
                    valid_nxt     = 1'b0;
                    last_nxt      = 1'b0;
                    remaining_nxt = '0;
                end else if ((!dout_valid || accept) && remaining != '0) begin
                    load          = 1'b1;
                    index_nxt     = index + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                end else if (accept || !dout_valid) begin
                    // Output drained with no beats left: the burst is over.
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            dout_nxt  = beat_err ? FILL : beat_data;
            err_nxt   = beat_err;
            valid_nxt = 1'b1;
            last_nxt  = (remaining_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            index      <= '0;
            remaining  <= '0;
            dout       <= FILL;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            index      <= index_nxt;
            remaining  <= remaining_nxt;
            dout       <= dout_nxt;
            dout_valid <= valid_nxt;
            dout_last  <= last_nxt;
            dout_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_vme_rd_burst_mux.sv
// Scoreboard bench for vme_rd_burst_mux: three instances (reversed 8ch, straight 8ch, straight 5ch)
// share one stimulus stream; each has its own expected-beat queue checked by a monitor.
module tb_vme_rd_burst_mux;

    logic        clk;
    logic        reset;
    logic [63:0] din;
    logic        rd_req;
    logic [2:0]  start_sel;
    logic [3:0]  burst_len;
    logic        abort;
    logic        dout_ready;

    logic        busy_w  [3];
    logic [7:0]  dout_w  [3];
    logic        valid_w [3];
    logic        last_w  [3];
    logic        err_w   [3];

    logic [7:0]  din_ch [8];
    logic        ready_random;
    int          checks;
    int          errors;

    logic [9:0]  q0[$];
    logic [9:0]  q1[$];
    logic [9:0]  q2[$];

    logic        stall_prev [3];
    logic [9:0]  prev_beat  [3];

    vme_rd_burst_mux #(.DW(8), .NCH(8), .SW(3), .SEL_REVERSE(1)) dut_rev8 (
        .clk(clk), .reset(reset), .din(din), .rd_req(rd_req), .start_sel(start_sel),
        .burst_len(burst_len), .abort(abort), .busy(busy_w[0]), .dout(dout_w[0]),
        .dout_valid(valid_w[0]), .dout_ready(dout_ready), .dout_last(last_w[0]), .dout_err(err_w[0])
    );

    vme_rd_burst_mux #(.DW(8), .NCH(8), .SW(3), .SEL_REVERSE(0)) dut_str8 (
        .clk(clk), .reset(reset), .din(din), .rd_req(rd_req), .start_sel(start_sel),
        .burst_len(burst_len), .abort(abort), .busy(busy_w[1]), .dout(dout_w[1]),
        .dout_valid(valid_w[1]), .dout_ready(dout_ready), .dout_last(last_w[1]), .dout_err(err_w[1])
    );

    vme_rd_burst_mux #(.DW(8), .NCH(5), .SW(3), .SEL_REVERSE(0)) dut_str5 (
        .clk(clk), .reset(reset), .din(din[39:0]), .rd_req(rd_req), .start_sel(start_sel),
        .burst_len(burst_len), .abort(abort), .busy(busy_w[2]), .dout(dout_w[2]),
        .dout_valid(valid_w[2]), .dout_ready(dout_ready), .dout_last(last_w[2]), .dout_err(err_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Random back-pressure, only when directed tests are not steering ready themselves.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_random) dout_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic int nchOf(input int inst);
        return (inst == 2) ? 5 : 8;
    endfunction

    function automatic bit revOf(input int inst);
        return (inst == 0);
    endfunction

    // Expected {err, last, data} of beat b of a burst, from the channel-mapping rules.
    function automatic logic [9:0] modelBeat(input int inst, input int start, input int b, input int total);
        int   idx;
        int   phys;
        logic err;
        logic [7:0] data;
        idx  = (start + b) % 8;
        phys = revOf(inst) ? (7 - idx) : idx;
        err  = (phys >= nchOf(inst));
        data = err ? 8'hFF : din_ch[phys];
        return {err, (b == total - 1), data};
    endfunction

    function automatic void pushExp(input int inst, input logic [9:0] v);
        case (inst)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int qSize(input int inst);
        case (inst)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [9:0] popExp(input int inst);
        case (inst)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void flushExp();
        q0.delete();
        q1.delete();
        q2.delete();
    endfunction

    task automatic setDin(input bit randomize);
        for (int k = 0; k < 8; k++) begin
            din_ch[k] = randomize ? 8'($urandom) : 8'(8'h10 + k);
            din[k*8 +: 8] = din_ch[k];
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Issues one request, records the expected beats and checks the one-cycle latency.
    task automatic applyStimulus(input int start, input int len);
        int total;
        @(posedge clk);
        #1;
        rd_req    = 1'b1;
        start_sel = 3'(start);
        burst_len = 4'(len);
        total     = (len == 0) ? 1 : len;
        for (int i = 0; i < 3; i++)
            for (int b = 0; b < total; b++)
                pushExp(i, modelBeat(i, start, b, total));
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("latency_valid%0d", i), 32'(valid_w[i]), 32'd1);
    endtask

    task automatic waitDone();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            if (qSize(0) == 0 && qSize(1) == 0 && qSize(2) == 0 &&
                !busy_w[0] && !busy_w[1] && !busy_w[2])
                done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL burst_timeout actual=q%0d/%0d/%0d required=empty", qSize(0), qSize(1), qSize(2));
            flushExp();
        end
    endtask

    task automatic checkIdle(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s_valid%0d", tag, i), 32'(valid_w[i]), 32'd0);
            checkOutput($sformatf("%s_busy%0d", tag, i), 32'(busy_w[i]), 32'd0);
        end
    endtask

    // Monitor: pops one expected beat per handshake, and checks the output stays put while stalled.
    always @(negedge clk) begin : monitor
        logic [9:0] act;
        for (int i = 0; i < 3; i++) begin
            act = {err_w[i], last_w[i], dout_w[i]};
            if (!reset && stall_prev[i] && valid_w[i])
                checkOutput($sformatf("hold%0d", i), 32'(act), 32'(prev_beat[i]));
            if (!reset && !abort && valid_w[i] && dout_ready) begin
                if (qSize(i) == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat%0d actual=%0h required=none", i, act);
                end else begin
                    checkOutput($sformatf("beat%0d", i), 32'(act), 32'(popExp(i)));
                end
            end
            stall_prev[i] = !reset && !abort && valid_w[i] && !dout_ready;
            prev_beat[i]  = act;
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        rd_req       = 1'b0;
        abort        = 1'b0;
        start_sel    = '0;
        burst_len    = '0;
        dout_ready   = 1'b1;
        ready_random = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall_prev[i] = 1'b0;
            prev_beat[i]  = '0;
        end
        setDin(1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("reset_beat%0d", i), 32'({err_w[i], last_w[i], dout_w[i]}), 32'h0FF);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single beat with burst_len 0");
        applyStimulus(0, 0);
        waitDone();

        $display("[TB] wrapping burst");
        applyStimulus(6, 4);
        waitDone();

        $display("[TB] back-pressure on second beat");
        applyStimulus(6, 4);
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dout_ready = 1'b1;
        waitDone();

        $display("[TB] out-of-range channels");
        applyStimulus(4, 3);
        waitDone();

        $display("[TB] din changes while a beat is held");
        dout_ready = 1'b0;
        applyStimulus(2, 1);
        setDin(1'b1);
        repeat (3) @(posedge clk);
        #1;
        dout_ready = 1'b1;
        waitDone();
        setDin(1'b0);

        $display("[TB] request held through the last accepted beat");
        applyStimulus(1, 3);
        rd_req    = 1'b1;
        start_sel = 3'd5;
        burst_len = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        checkIdle("ignore");
        repeat (3) @(negedge clk);

        $display("[TB] abort after two beats");
        applyStimulus(0, 6);
        @(posedge clk);
        #1;
        rd_req    = 1'b1;
        start_sel = 3'd7;
        burst_len = 4'd1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        abort  = 1'b1;
        flushExp();
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkIdle("abort");
        applyStimulus(3, 2);
        waitDone();

        $display("[TB] reset in the middle of a burst");
        applyStimulus(0, 6);
        @(posedge clk);
        #1;
        reset = 1'b1;
        abort = 1'b1;
        flushExp();
        @(posedge clk);
        @(negedge clk);
        checkIdle("midreset");
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("midreset_dout%0d", i), 32'(dout_w[i]), 32'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        checkIdle("postreset");

        $display("[TB] randomized bursts");
        ready_random = 1'b1;
        for (int n = 0; n < 40; n++) begin
            setDin(1'b1);
            applyStimulus($urandom_range(0, 7), $urandom_range(0, 15));
            waitDone();
        end
        ready_random = 1'b0;
        dout_ready   = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vme_rd_burst_mux.md
Name: vme_rd_burst_mux

Overview:
- Parametrised, registered read-back multiplexer for the VME64x slave register file.
- Selects one of NCH data channels, each DW bits wide. Replaces the fixed 4:1 byte mux.
- Adds burst reads of consecutive channels with wrap-around, a valid/ready output handshake, abort, and out-of-range flagging.
- Sits between the register bank and the VME data-bus driver.

Parameters:
- DW, 8, channel/data width in bits.
- NCH, 8, number of channels (2..2**SW).
- SW, 3, select/index width.
- SEL_REVERSE, 1: when 1, physical channel = (2**SW-1) - index (legacy mapping: index 0 reads top channel); when 0, physical = index.
- FILL, all-ones of DW, value driven for an out-of-range physical channel.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- din  in  NCH*DW  channel data, flat; channel k at din[k*DW +: DW].
- rd_req  in  1  start request; sampled only in IDLE.
- start_sel  in  SW  first index of the burst.
- burst_len  in  SW+1  beats in the burst; 0 is treated as 1.
- abort  in  1  terminate current burst.
- busy  out  1  high in BURST state.
- dout  out  DW  registered read data.
- dout_valid  out  1  dout holds a beat.
- dout_ready  in  1  consumer accepts the beat when valid & ready.
- dout_last  out  1  final beat of the burst, qualified by dout_valid.
- dout_err  out  1  current beat's physical channel >= NCH, qualified by dout_valid.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: dout = FILL, dout_valid = 0, dout_last = 0, dout_err = 0, busy = 0. State = IDLE; index and remaining-beat counters = 0.
- States: IDLE and BURST.
- IDLE -> BURST on rd_req = 1 (acceptance edge):
  - index <= start_sel + 1 (mod 2**SW).
  - remaining <= max(burst_len,1) - 1.
  - First beat (start_sel) loaded into the output register on the same edge: dout_valid = 1 one cycle after rd_req.
- Beat load: when the output register is empty, or holds a beat being accepted (valid & ready), and beats remain:
  - dout <= din of the physical channel for the current index, sampled at the load edge.
  - dout_err set if physical channel >= NCH; in that case dout <= FILL.
  - dout_last = 1 when the loaded beat is the final one.
  - index increments, wrapping 2**SW-1 -> 0; remaining decrements.
- Back-pressure: while dout_valid & !dout_ready, dout, dout_last and dout_err hold stable and no new beat loads.
- Throughput: one beat per cycle with dout_ready held high. Latency rd_req -> first valid: 1 cycle.
- BURST -> IDLE when the last beat is accepted (valid & ready & last). dout_valid drops the next cycle unless a new burst starts.
- A new rd_req is sampled in IDLE only. It is ignored while busy, including on the same cycle the last beat is accepted. Back-to-back bursts therefore have a minimum 1-cycle gap in valid.
- abort = 1 in BURST: next edge clears dout_valid, dout_last and remaining, returns to IDLE, and discards any presented beat. abort in IDLE has no effect.
- Simultaneous abort and reset: reset wins. Reset mid-burst drops valid on the next edge with no further beats.
- burst_len > NCH is legal: indices wrap, and channels repeat in order.
- din changes after a beat is loaded do not alter the presented dout.

Test Plan:
- Reset: assert reset 2 cycles mid-burst -> next cycle dout_valid = 0, busy = 0, dout = 8'hFF; no beats follow.
- Single beat, defaults: din ch0..7 = 8'h10..8'h17, start_sel = 0, burst_len = 0, ready = 1 -> one beat dout = 8'h17 (reversed), last = 1, err = 0, valid exactly 1 cycle after rd_req.
- Wrap burst, SEL_REVERSE = 0: start_sel = 6, burst_len = 4, ready = 1 -> dout 8'h16, 8'h17, 8'h10, 8'h11 on 4 consecutive cycles; last only on 8'h11.
- Back-pressure: same burst, ready low for 3 cycles on beat 2 -> beat 2 held stable 3 cycles, no beat lost or duplicated, total 4 beats.
- Out of range: NCH = 5, SEL_REVERSE = 0, start_sel = 4, burst_len = 3 -> beats din[4], then FILL with err = 1, then FILL with err = 1.
- Abort and ignored request: abort after beat 2 of 6 -> valid low next cycle, busy low. rd_req asserted during the burst is ignored; rd_req after abort starts a fresh burst from its own start_sel.
